// File: rtl/seq_circuit_sequencer.sv
// seq_circuit_sequencer: steps the lab sequential circuit through a programmed vector list and scores Y/Z
module seq_circuit_sequencer #(
   parameter int SETTLE_CYC = 4,
   parameter int PULSE_CYC  = 2,
   parameter int AW         = 3
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          start,
   input  logic          vec_wr_en,
   input  logic [AW-1:0] vec_wr_addr,
   input  logic [3:0]    vec_wr_data,
   input  logic [AW:0]   num_vec,
   output logic          dut_A,
   output logic          dut_B,
   output logic          dut_clk,
   input  logic          dut_Y,
   input  logic          dut_Z,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW:0]   err_count,
   output logic [AW-1:0] fail_idx,
   output logic [AW-1:0] cur_idx
);
   localparam int NVEC = 2 ** AW;
   localparam int CW   = $clog2((SETTLE_CYC > PULSE_CYC ? SETTLE_CYC : PULSE_CYC) + 1);

   typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK, NEXT, DONE} state_t;

   state_t          state;
   logic [3:0]      mem [NVEC];
   logic [CW-1:0]   cnt;
   logic [AW:0]     n_r;
   logic [AW:0]     n_clamp;
   logic [1:0]      ab_first;
   logic [1:0]      ab_next;
   logic            last;
   logic            mismatch;

   assign n_clamp  = (num_vec > (AW+1)'(NVEC)) ? (AW+1)'(NVEC) : num_vec;
   assign ab_first = (vec_wr_en && vec_wr_addr == '0) ? vec_wr_data[3:2] : mem[0][3:2];
   assign ab_next  = mem[cur_idx + 1'b1][3:2];
   assign last     = ({1'b0, cur_idx} + 1'b1) == n_r;
   assign mismatch = {dut_Y, dut_Z} != mem[cur_idx][1:0];

   // vector store: host writes land only while no run is in progress; contents survive reset
   always_ff @(posedge CLK)
      if (vec_wr_en && !busy) mem[vec_wr_addr] <= vec_wr_data;

   // run controller: each output is set on the transition into the state that owns it
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         state     <= IDLE;
         cnt       <= '0;
         n_r       <= '0;
         dut_A     <= 1'b0;
         dut_B     <= 1'b0;
         dut_clk   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_idx  <= '0;
         cur_idx   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  n_r       <= n_clamp;
                  cur_idx   <= '0;
                  err_count <= '0;
                  fail_idx  <= '0;
                  pass      <= 1'b0;
                  busy      <= 1'b1;
                  cnt       <= CW'(SETTLE_CYC - 1);
                  if (n_clamp == '0) state <= DONE;
                  else begin
                     state <= SETUP;
                     dut_A <= ab_first[1];
                     dut_B <= ab_first[0];
                  end
               end
            SETUP:
               if (cnt == '0) begin
                  state   <= PULSE;
                  cnt     <= CW'(PULSE_CYC - 1);
                  dut_clk <= 1'b1;
               end else cnt <= cnt - 1'b1;
            PULSE:
               if (cnt == '0) begin
                  state   <= HOLD;
                  cnt     <= CW'(SETTLE_CYC - 1);
                  dut_clk <= 1'b0;
               end else cnt <= cnt - 1'b1;
            HOLD:
               if (cnt == '0) state <= CHECK;
               else cnt <= cnt - 1'b1;
            CHECK: begin
               state <= NEXT;
               if (mismatch) begin
                  err_count <= err_count + 1'b1;
                  if (err_count == '0) fail_idx <= cur_idx;
               end
            end
            NEXT:
               if (last) state <= DONE;
               else begin
                  state   <= SETUP;
                  cur_idx <= cur_idx + 1'b1;
                  cnt     <= CW'(SETTLE_CYC - 1);
                  dut_A   <= ab_next[1];
                  dut_B   <= ab_next[0];
               end
            DONE: begin
               state <= IDLE;
               done  <= 1'b1;
               busy  <= 1'b0;
               pass  <= err_count == '0;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_seq_circuit_sequencer.sv
// tb_seq_circuit_sequencer: randomized runs of the sequencer against a toggle/latch circuit and a vector-list model
module tb_seq_circuit_sequencer;
   localparam int S  = 4;
   localparam int P  = 2;
   localparam int AW = 3;
   localparam int NV = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          start = 1'b0;
   logic          vec_wr_en = 1'b0;
   logic [AW-1:0] vec_wr_addr = '0;
   logic [3:0]    vec_wr_data = '0;
   logic [AW:0]   num_vec = '0;
   logic          dut_A, dut_B, dut_clk, busy, done, pass;
   logic [AW:0]   err_count;
   logic [AW-1:0] fail_idx, cur_idx;
   logic          cy = 1'b0;
   logic          cz = 1'b0;
   logic          cr = 1'b0;
   logic [3:0]    vec [NV];
   int            n_chk = 0;
   int            n_pass = 0;

   seq_circuit_sequencer #(.SETTLE_CYC(S), .PULSE_CYC(P), .AW(AW)) dut (
      .CLK(CLK), .RST(RST), .start(start), .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr),
      .vec_wr_data(vec_wr_data), .num_vec(num_vec), .dut_A(dut_A), .dut_B(dut_B), .dut_clk(dut_clk),
      .dut_Y(cy), .dut_Z(cz), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_idx(fail_idx), .cur_idx(cur_idx)
   );

   always #5 CLK = ~CLK;

   // circuit under test: Y toggles when A is high, Z captures B, on each rising dut_clk
   always @(posedge dut_clk or posedge cr)
      if (cr) begin
         cy <= 1'b0;
         cz <= 1'b0;
      end else begin
         cy <= cy ^ dut_A;
         cz <= dut_B;
      end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic load(input int a, input logic [3:0] d);
      @(negedge CLK);
      vec_wr_en   = 1'b1;
      vec_wr_addr = a[AW-1:0];
      vec_wr_data = d;
      vec[a]      = d;
      @(negedge CLK);
      vec_wr_en = 1'b0;
   endtask

   task automatic golden(input int n);
      logic y, z, a, b;
      y = 1'b0;
      z = 1'b0;
      for (int i = 0; i < n; i++) begin
         a = 1'($urandom);
         b = 1'($urandom);
         y = y ^ a;
         z = b;
         load(i, {a, b, y, z});
      end
   endtask

   task automatic predict(input int n, output int e, output int f);
      logic y, z;
      y = 1'b0;
      z = 1'b0;
      e = 0;
      f = 0;
      for (int i = 0; i < n; i++) begin
         y = y ^ vec[i][3];
         z = vec[i][2];
         if ({y, z} != vec[i][1:0]) begin
            if (e == 0) f = i;
            e++;
         end
      end
   endtask

   task automatic run(input int nv, input int inj, input int abort_vec, input bit ws);
      int n, e, f, bc, hi, pl, abe, dc;
      bit dn, prev, ab;
      logic [3:0] d;
      n = nv > NV ? NV : nv;
      bc = 0; hi = 0; pl = 0; abe = 0; dc = 0; dn = 0; prev = 0; ab = 0;
      @(negedge CLK);
      cr      = 1'b1;
      num_vec = nv[AW:0];
      start   = 1'b1;
      if (ws) begin
         d           = 4'($urandom);
         vec_wr_en   = 1'b1;
         vec_wr_addr = '0;
         vec_wr_data = d;
         vec[0]      = d;
      end
      @(negedge CLK);
      start     = 1'b0;
      cr        = 1'b0;
      vec_wr_en = 1'b0;
      num_vec   = (AW+1)'($urandom);
      predict(n, e, f);
      for (int c = 0; c < 400; c++) begin
         if (c == inj) begin
            start       = 1'b1;
            vec_wr_en   = 1'b1;
            vec_wr_addr = AW'($urandom);
            vec_wr_data = ~vec[vec_wr_addr];
         end else if (c == inj + 1) begin
            start     = 1'b0;
            vec_wr_en = 1'b0;
         end
         if (busy) bc++;
         if (dut_clk) begin
            hi++;
            if (!prev) begin
               if (pl >= NV || {dut_A, dut_B} !== vec[pl][3:2]) abe++;
               pl++;
            end
         end
         prev = dut_clk;
         if (abort_vec >= 0 && dut_clk && pl == abort_vec + 1) begin
            ab = 1;
            break;
         end
         if (done) begin
            dn = 1;
            break;
         end
         @(negedge CLK);
      end
      start     = 1'b0;
      vec_wr_en = 1'b0;
      if (ab) begin
         RST = 1'b0;
         #1;
         chk("abort_outputs", int'({dut_A, dut_B, dut_clk, busy, done, pass, err_count, fail_idx, cur_idx}), 0);
         chk("abort_ab_before", abe, 0);
         repeat (2) @(negedge CLK);
         RST = 1'b1;
         repeat (30) begin
            @(negedge CLK);
            if (done || busy) dc++;
         end
         chk("abort_no_done", dc, 0);
      end else begin
         chk("done_seen", int'(dn), 1);
         chk("busy_cycles", bc, n * (2 * S + P + 2) + 1);
         chk("clk_high_cycles", hi, n * P);
         chk("clk_pulses", pl, n);
         chk("ab_drive", abe, 0);
         chk("busy_at_done", int'(busy), 0);
         chk("err_count", int'(err_count), e);
         chk("fail_idx", int'(fail_idx), f);
         chk("pass", int'(pass), int'(e == 0));
         chk("cur_idx_end", int'(cur_idx), n == 0 ? 0 : n - 1);
         @(negedge CLK);
         chk("done_width", int'(done), 0);
      end
   endtask

   initial begin
      cr = 1'b1;
      repeat (3) @(negedge CLK);
      chk("reset_outputs", int'({dut_A, dut_B, dut_clk, busy, done, pass, err_count, fail_idx, cur_idx}), 0);
      RST = 1'b1;
      cr  = 1'b0;
      golden(4);
      run(4, -1, -1, 0);
      chk("t1_pass", int'(pass), 1);
      load(1, vec[1] ^ 4'b0010);
      load(3, vec[3] ^ 4'b0010);
      run(4, -1, -1, 0);
      chk("t2_err_count", int'(err_count), 2);
      chk("t2_fail_idx", int'(fail_idx), 1);
      run(0, -1, -1, 0);
      chk("t3_pass", int'(pass), 1);
      golden(8);
      run(15, -1, -1, 0);
      chk("t4_cur_idx", int'(cur_idx), 7);
      run(4, 10, -1, 0);
      run(8, -1, -1, 0);
      run(4, -1, 2, 0);
      run(4, -1, -1, 0);
      run(5, -1, -1, 1);
      repeat (12) begin
         int nv, inj, nb;
         golden(8);
         nb = $urandom_range(0, 3);
         for (int k = 0; k < nb; k++) begin
            int a;
            a = $urandom_range(0, NV - 1);
            load(a, vec[a] ^ 4'($urandom_range(1, 3)));
         end
         nv  = $urandom_range(0, 15);
         inj = (nv >= 2) ? $urandom_range(1, 12 * (nv > NV ? NV : nv) - 5) : -1;
         run(nv, inj, -1, 1'($urandom));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
